// File: rtl/sar_scan_sequencer_if.sv
// ADC-side handshake between the scan sequencer (master) and the SAR controller (slave).
// Carries the mux select, the conversion start pulse and the returned result.
`timescale 1ns/1ps
interface sar_scan_sequencer_if #(
  parameter int CHW   = 2,
  parameter int WIDTH = 8
);
  logic             adc_go;
  logic             adc_valid;
  logic [WIDTH-1:0] adc_result;
  logic [CHW-1:0]   ch_sel;

  modport master (output adc_go, output ch_sel, input adc_valid, input adc_result);
  modport slave  (input adc_go, input ch_sel, output adc_valid, output adc_result);
endinterface

// File: rtl/sar_scan_sequencer.sv
// Round-robin scan scheduler sharing one SAR ADC controller across NCH muxed inputs.
// Optional window comparator with sticky per-channel alarm when WINDOW_CMP_EN is defined.
`timescale 1ns/1ps
module sar_scan_sequencer #(
  parameter int NCH     = 4,
  parameter int CHW     = 2,
  parameter int WIDTH   = 8,
  parameter int SETTLE  = 3,
  parameter int TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 start,
  input  logic                 mode,
  input  logic [NCH-1:0]       ch_mask,
  sar_scan_sequencer_if.master adc,
  output logic                 busy,
  output logic                 done,
  output logic [NCH-1:0]       new_flags,
  input  logic [NCH-1:0]       clr_flags,
  output logic                 timeout_err,
  input  logic [CHW-1:0]       rd_ch,
  output logic [WIDTH-1:0]     rd_data
`ifdef WINDOW_CMP_EN
  ,
  input  logic [WIDTH-1:0]     win_lo,
  input  logic [WIDTH-1:0]     win_hi,
  output logic [NCH-1:0]       alarm
`endif
);

  localparam int CNT_MAX = (TIMEOUT > SETTLE) ? TIMEOUT : SETTLE;
  localparam int CW      = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {S_IDLE, S_SETTLE, S_GO, S_WAIT, S_NEXT} state_t;

  state_t           state_q, state_d;
  logic [NCH-1:0]   mask_q, mask_d;
  logic [NCH-1:0]   new_flags_q, new_flags_d;
  logic [CHW-1:0]   ch_sel_q, ch_sel_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             valid_q, valid_d;
  logic             timeout_err_q, timeout_err_d;
  logic [WIDTH-1:0] res_q [NCH];
  logic [WIDTH-1:0] res_d [NCH];

  logic             store;
  logic [NCH-1:0]   ch_onehot;
  logic [CHW-1:0]   start_ch, first_ch, higher_ch;
  logic             higher_found;

  // Descending scan so the last hit is the lowest qualifying index.
  always_comb begin
    start_ch     = '0;
    first_ch     = '0;
    higher_ch    = '0;
    higher_found = 1'b0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (ch_mask[i]) start_ch = CHW'(i);
      if (mask_q[i])  first_ch = CHW'(i);
      if (mask_q[i] && (CHW'(i) > ch_sel_q)) begin
        higher_ch    = CHW'(i);
        higher_found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    mask_d        = mask_q;
    ch_sel_d      = ch_sel_q;
    cnt_d         = cnt_q;
    timeout_err_d = timeout_err_q;
    store         = 1'b0;
    done          = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && en && (|ch_mask)) begin
          mask_d        = ch_mask;
          timeout_err_d = 1'b0;
          ch_sel_d      = start_ch;
          cnt_d         = CW'(SETTLE - 1);
          state_d       = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (cnt_q == '0) state_d = S_GO;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_GO: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      // Only a rising valid is accepted; a level left from the previous conversion is stale.
      S_WAIT: begin
        if (adc.adc_valid && !valid_q) begin
          store   = 1'b1;
          state_d = S_NEXT;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          timeout_err_d = 1'b1;
          state_d       = S_NEXT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_NEXT: begin
        if (!en) begin
          state_d = S_IDLE;
        end else if (higher_found) begin
          ch_sel_d = higher_ch;
          cnt_d    = CW'(SETTLE - 1);
          state_d  = S_SETTLE;
        end else begin
          done = 1'b1;
          if (mode) begin
            ch_sel_d = first_ch;
            cnt_d    = CW'(SETTLE - 1);
            state_d  = S_SETTLE;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign ch_onehot = NCH'(1) << ch_sel_q;
  assign valid_d   = adc.adc_valid;

  // A fresh store beats a same-cycle write-1-to-clear.
  assign new_flags_d = (new_flags_q & ~clr_flags) | (store ? ch_onehot : '0);

  always_comb begin
    res_d = res_q;
    if (store) res_d[ch_sel_q] = adc.adc_result;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      mask_q        <= '0;
      new_flags_q   <= '0;
      ch_sel_q      <= '0;
      cnt_q         <= '0;
      valid_q       <= 1'b0;
      timeout_err_q <= 1'b0;
      for (int i = 0; i < NCH; i++) res_q[i] <= '0;
    end else begin
      state_q       <= state_d;
      mask_q        <= mask_d;
      new_flags_q   <= new_flags_d;
      ch_sel_q      <= ch_sel_d;
      cnt_q         <= cnt_d;
      valid_q       <= valid_d;
      timeout_err_q <= timeout_err_d;
      res_q         <= res_d;
    end
  end

  assign adc.adc_go   = (state_q == S_GO);
  assign adc.ch_sel   = ch_sel_q;
  assign busy         = (state_q != S_IDLE);
  assign new_flags    = new_flags_q;
  assign timeout_err  = timeout_err_q;
  assign rd_data      = (int'(rd_ch) < NCH) ? res_q[rd_ch] : '0;

`ifdef WINDOW_CMP_EN
  logic [NCH-1:0] alarm_q, alarm_d;
  logic           out_of_window;

  assign out_of_window = (adc.adc_result < win_lo) || (adc.adc_result > win_hi);
  assign alarm_d       = (alarm_q & ~clr_flags) | ((store && out_of_window) ? ch_onehot : '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) alarm_q <= '0;
    else      alarm_q <= alarm_d;
  end

  assign alarm = alarm_q;
`endif

endmodule

// File: tb/tb_sar_scan_sequencer.sv
// Self-checking bench for sar_scan_sequencer: SAR controller responder, monitor and scan-level reference model.
// Builds with or without WINDOW_CMP_EN.
`timescale 1ns/1ps
module tb_sar_scan_sequencer;
  localparam int NCH = 4, CHW = 2, WIDTH = 8, SETTLE = 3, TIMEOUT = 64;

  logic clk = 1'b0, rst = 1'b0, en = 1'b0, start = 1'b0, mode = 1'b0;
  logic [NCH-1:0] ch_mask = '0, clr_flags = '0, new_flags;
  logic busy, done, timeout_err;
  logic [CHW-1:0] rd_ch = '0;
  logic [WIDTH-1:0] rd_data;
`ifdef WINDOW_CMP_EN
  logic [WIDTH-1:0] win_lo = '0, win_hi = '0;
  logic [NCH-1:0] alarm;
`endif

  sar_scan_sequencer_if #(.CHW(CHW), .WIDTH(WIDTH)) adc_if ();

  sar_scan_sequencer #(.NCH(NCH), .CHW(CHW), .WIDTH(WIDTH), .SETTLE(SETTLE), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .en(en), .start(start), .mode(mode), .ch_mask(ch_mask),
    .adc(adc_if), .busy(busy), .done(done), .new_flags(new_flags), .clr_flags(clr_flags),
    .timeout_err(timeout_err), .rd_ch(rd_ch), .rd_data(rd_data)
`ifdef WINDOW_CMP_EN
    , .win_lo(win_lo), .win_hi(win_hi), .alarm(alarm)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0, n_fail = 0;
  int done_cnt = 0, terr_cyc = -1;
  int go_ch[$];
  int go_cyc[$];

  // Responder state and scan-level reference model state.
  logic [WIDTH-1:0] resp_val [NCH];
  logic [NCH-1:0]   resp_silent = '0;
  int               resp_lat = 10;
  bit               resp_hold = 1'b0;
  logic [WIDTH-1:0] exp_res [NCH];
  logic [NCH-1:0]   exp_flags = '0;
  int               exp_order[$];
  logic             exp_terr;

  // SAR controller model: answers lat cycles after go; in hold mode valid stays high into the next WAIT.
  initial begin
    int pend = 0, hold_cnt = 0, pend_ch = 0;
    adc_if.adc_valid  = 1'b0;
    adc_if.adc_result = '0;
    forever begin
      @(posedge clk); #1;
      if (!rst) begin
        pend = 0; hold_cnt = 0;
        adc_if.adc_valid = 1'b0;
      end else begin
        if (!resp_hold) adc_if.adc_valid = 1'b0;
        if (hold_cnt > 0) begin
          hold_cnt--;
          if (hold_cnt == 0) adc_if.adc_valid = 1'b0;
        end
        if (pend > 0) begin
          pend--;
          if (pend == 0) begin
            adc_if.adc_valid  = 1'b1;
            adc_if.adc_result = resp_val[pend_ch];
          end
        end
        if (adc_if.adc_go) begin
          if (!resp_silent[adc_if.ch_sel]) begin
            pend = resp_lat;
            pend_ch = int'(adc_if.ch_sel);
          end
          hold_cnt = 2;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        if (adc_if.adc_go) begin
          go_ch.push_back(int'(adc_if.ch_sel));
          go_cyc.push_back(cyc);
        end
        if (done) done_cnt++;
        if (timeout_err && terr_cyc < 0) terr_cyc = cyc;
      end
    end
  end

  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Expected scan outcome from the channel-order rules: ascending set bits, silent channels time out.
  function automatic void model_scan(input logic [NCH-1:0] mask, input logic [NCH-1:0] silent);
    exp_order.delete();
    exp_terr = 1'b0;
    for (int ch = 0; ch < NCH; ch++) begin
      if (mask[ch]) begin
        exp_order.push_back(ch);
        if (silent[ch]) exp_terr = 1'b1;
        else begin
          exp_res[ch]   = resp_val[ch];
          exp_flags[ch] = 1'b1;
        end
      end
    end
  endfunction

  task automatic clear_mon();
    go_ch.delete();
    go_cyc.delete();
    done_cnt = 0;
    terr_cyc = -1;
  endtask

  task automatic pulse_start(input logic [NCH-1:0] mask, input logic md, output int sc);
    @(posedge clk); #1;
    ch_mask = mask; mode = md; start = 1'b1; sc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic pulse_clear(input logic [NCH-1:0] bits);
    @(posedge clk); #1;
    clr_flags = bits;
    @(posedge clk); #1;
    clr_flags = '0;
  endtask

  task automatic wait_idle(input string name);
    int k = 0;
    do begin @(negedge clk); k++; end while (busy && k < 3000);
    n_checks++;
    if (busy) begin n_fail++; $display("[TB] FAIL %s idle_wait: busy=%0b required 0", name, busy); end
  endtask

  task automatic wait_go(input string name);
    int k = 0;
    do begin @(negedge clk); k++; end while (!adc_if.adc_go && k < 300);
    n_checks++;
    if (!adc_if.adc_go) begin n_fail++; $display("[TB] FAIL %s go_wait: adc_go=0 required 1", name); end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      en = 1'($urandom); start = 1'($urandom); mode = 1'($urandom);
      ch_mask = NCH'($urandom); clr_flags = NCH'($urandom);
      @(negedge clk);
      n_checks++;
      if ({adc_if.adc_go, busy, done, timeout_err, adc_if.ch_sel, new_flags} !== '0) begin
        n_fail++;
        $display("[TB] FAIL reset_outputs: go=%0b busy=%0b done=%0b terr=%0b ch_sel=%0d flags=%b required all 0",
                 adc_if.adc_go, busy, done, timeout_err, adc_if.ch_sel, new_flags);
      end
    end
    for (int ch = 0; ch < NCH; ch++) begin
      rd_ch = CHW'(ch); #1;
      n_checks++;
      if (rd_data !== '0) begin n_fail++; $display("[TB] FAIL reset_rd_data[%0d]: got %0h required 0", ch, rd_data); end
      exp_res[ch] = '0;
    end
    en = 1'b0; start = 1'b0; mode = 1'b0; ch_mask = '0; clr_flags = '0;
    @(negedge clk); rst = 1'b1;
  endtask

  task automatic test_single_scan();
    int sc, dummy;
    for (int ch = 0; ch < NCH; ch++) resp_val[ch] = WIDTH'(8'h10 + ch);
    resp_silent = '0; resp_lat = 10; resp_hold = 1'b0;
    exp_flags = '0;
    clear_mon();
    en = 1'b1;
    pulse_start(4'b1011, 1'b0, sc);
    wait_go("single");
    pulse_start(4'b0100, 1'b0, dummy);
    wait_idle("single");
    model_scan(4'b1011, 4'b0000);
    n_checks++;
    if (go_ch.size() != exp_order.size()) begin
      n_fail++; $display("[TB] FAIL single_go_count: got %0d required %0d", go_ch.size(), exp_order.size());
    end else begin
      for (int i = 0; i < exp_order.size(); i++) begin
        n_checks++;
        if (go_ch[i] != exp_order[i]) begin n_fail++; $display("[TB] FAIL single_ch_seq[%0d]: got %0d required %0d", i, go_ch[i], exp_order[i]); end
      end
      n_checks++;
      if (go_cyc[0] - sc != SETTLE + 1) begin n_fail++; $display("[TB] FAIL single_go_latency: got %0d required %0d", go_cyc[0] - sc, SETTLE + 1); end
    end
    n_checks++;
    if (done_cnt != 1) begin n_fail++; $display("[TB] FAIL single_done_count: got %0d required 1", done_cnt); end
    n_checks++;
    if (new_flags !== exp_flags) begin n_fail++; $display("[TB] FAIL single_new_flags: got %b required %b", new_flags, exp_flags); end
    n_checks++;
    if (timeout_err !== 1'b0) begin n_fail++; $display("[TB] FAIL single_timeout_err: got %0b required 0", timeout_err); end
    for (int ch = 0; ch < NCH; ch++) begin
      rd_ch = CHW'(ch); #1;
      n_checks++;
      if (rd_data !== exp_res[ch]) begin n_fail++; $display("[TB] FAIL single_res[%0d]: got %0h required %0h", ch, rd_data, exp_res[ch]); end
    end
  endtask

  task automatic test_ignored_start();
    int sc;
    clear_mon();
    en = 1'b0;
    pulse_start(4'b1111, 1'b0, sc);
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL ignore_en0_busy: got %0b required 0", busy); end
    en = 1'b1;
    pulse_start(4'b0000, 1'b0, sc);
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL ignore_mask0_busy: got %0b required 0", busy); end
    repeat (SETTLE + 4) @(negedge clk);
    n_checks++;
    if (go_ch.size() != 0) begin n_fail++; $display("[TB] FAIL ignore_go_count: got %0d required 0", go_ch.size()); end
  endtask

  task automatic test_timeout();
    int sc;
    pulse_clear('1);
    exp_flags = '0;
    @(negedge clk);
    n_checks++;
    if (new_flags !== '0) begin n_fail++; $display("[TB] FAIL timeout_pre_clear: got %b required 0000", new_flags); end
    for (int ch = 0; ch < NCH; ch++) resp_val[ch] = WIDTH'(8'h20 + ch);
    resp_silent = 4'b0010;
    clear_mon();
    pulse_start(4'b1011, 1'b0, sc);
    wait_idle("timeout");
    model_scan(4'b1011, resp_silent);
    n_checks++;
    if (timeout_err !== exp_terr) begin n_fail++; $display("[TB] FAIL timeout_err: got %0b required %0b", timeout_err, exp_terr); end
    n_checks++;
    if (go_ch.size() != 3) begin
      n_fail++; $display("[TB] FAIL timeout_go_count: got %0d required 3", go_ch.size());
    end else begin
      n_checks++;
      if (go_ch[2] != 3) begin n_fail++; $display("[TB] FAIL timeout_last_ch: got %0d required 3", go_ch[2]); end
      n_checks++;
      if (terr_cyc - go_cyc[1] != TIMEOUT + 1) begin
        n_fail++; $display("[TB] FAIL timeout_delay: got %0d required %0d", terr_cyc - go_cyc[1], TIMEOUT + 1);
      end
    end
    n_checks++;
    if (done_cnt != 1) begin n_fail++; $display("[TB] FAIL timeout_done_count: got %0d required 1", done_cnt); end
    n_checks++;
    if (new_flags !== exp_flags) begin n_fail++; $display("[TB] FAIL timeout_new_flags: got %b required %b", new_flags, exp_flags); end
    for (int ch = 0; ch < NCH; ch++) begin
      rd_ch = CHW'(ch); #1;
      n_checks++;
      if (rd_data !== exp_res[ch]) begin n_fail++; $display("[TB] FAIL timeout_res[%0d]: got %0h required %0h", ch, rd_data, exp_res[ch]); end
    end
    resp_silent = '0;
  endtask

  task automatic test_continuous();
    int sc, k, dones_before;
    resp_val[0] = 8'h5A; resp_lat = 10; resp_hold = 1'b0;
    pulse_clear('1);
    exp_flags = '0;
    clear_mon();
    en = 1'b1;
    pulse_start(4'b0001, 1'b1, sc);
    k = 0;
    do begin @(negedge clk); k++; end while (done_cnt < 3 && k < 1000);
    n_checks++;
    if (done_cnt != 3 || go_ch.size() != 3) begin
      n_fail++; $display("[TB] FAIL cont_done_per_conv: done=%0d go=%0d required 3 and 3", done_cnt, go_ch.size());
    end
    n_checks++;
    if (timeout_err !== 1'b0) begin n_fail++; $display("[TB] FAIL cont_terr_cleared: got %0b required 0", timeout_err); end
    wait_go("cont");
    resp_val[0] = 8'hA5;
    en = 1'b0;
    clr_flags = '1;
    @(posedge clk); #1;
    clr_flags = '0;
    @(negedge clk);
    n_checks++;
    if (new_flags !== '0) begin n_fail++; $display("[TB] FAIL cont_flags_cleared: got %b required 0000", new_flags); end
    k = 0;
    while (!adc_if.adc_valid && k < 200) begin @(negedge clk); k++; end
    clr_flags = 4'b0001;
    @(posedge clk); #1;
    clr_flags = '0;
    dones_before = done_cnt;
    wait_idle("cont");
    exp_res[0] = 8'hA5;
    exp_flags = 4'b0001;
    n_checks++;
    if (new_flags !== exp_flags) begin n_fail++; $display("[TB] FAIL cont_set_wins: got %b required %b", new_flags, exp_flags); end
    n_checks++;
    if (done_cnt != dones_before || go_ch.size() != 4) begin
      n_fail++; $display("[TB] FAIL cont_stop_no_done: done=%0d go=%0d required %0d and 4", done_cnt, go_ch.size(), dones_before);
    end
    rd_ch = '0; #1;
    n_checks++;
    if (rd_data !== exp_res[0]) begin n_fail++; $display("[TB] FAIL cont_last_res: got %0h required %0h", rd_data, exp_res[0]); end
    mode = 1'b0;
    en = 1'b1;
  endtask

  task automatic test_mid_reset();
    int sc;
    for (int ch = 0; ch < NCH; ch++) resp_val[ch] = WIDTH'(8'h30 + ch);
    pulse_start(4'b1011, 1'b0, sc);
    wait_go("midrst");
    rst = 1'b0;
    #1;
    n_checks++;
    if (adc_if.adc_go !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("[TB] FAIL midrst_async: go=%0b busy=%0b required 0 and 0", adc_if.adc_go, busy);
    end
    n_checks++;
    if (new_flags !== '0) begin n_fail++; $display("[TB] FAIL midrst_flags: got %b required 0000", new_flags); end
    for (int ch = 0; ch < NCH; ch++) begin
      exp_res[ch] = '0;
      rd_ch = CHW'(ch); #1;
      n_checks++;
      if (rd_data !== '0) begin n_fail++; $display("[TB] FAIL midrst_res[%0d]: got %0h required 0", ch, rd_data); end
    end
    exp_flags = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    clear_mon();
    pulse_start(4'b1011, 1'b0, sc);
    wait_idle("midrst");
    model_scan(4'b1011, 4'b0000);
    n_checks++;
    if (go_ch.size() != 3 || go_ch[0] != 0) begin
      n_fail++; $display("[TB] FAIL midrst_restart: go_count=%0d first_ch=%0d required 3 and 0", go_ch.size(), (go_ch.size() > 0) ? go_ch[0] : -1);
    end
    n_checks++;
    if (new_flags !== exp_flags) begin n_fail++; $display("[TB] FAIL midrst_new_flags: got %b required %b", new_flags, exp_flags); end
  endtask

  task automatic test_random();
    int sc;
    logic [NCH-1:0] mask;
    for (int it = 0; it < 20; it++) begin
      mask = NCH'($urandom_range(1, (1 << NCH) - 1));
      for (int ch = 0; ch < NCH; ch++) resp_val[ch] = WIDTH'($urandom);
      resp_silent = ($urandom_range(0, 5) == 0) ? NCH'($urandom) : '0;
      resp_lat = $urandom_range(3, 30);
      resp_hold = 1'($urandom);
      pulse_clear('1);
      exp_flags = '0;
      clear_mon();
      pulse_start(mask, 1'b0, sc);
      wait_idle("random");
      model_scan(mask, resp_silent);
      n_checks++;
      if (go_ch.size() != exp_order.size()) begin
        n_fail++; $display("[TB] FAIL rand%0d_go_count: got %0d required %0d", it, go_ch.size(), exp_order.size());
      end else begin
        for (int i = 0; i < exp_order.size(); i++) begin
          n_checks++;
          if (go_ch[i] != exp_order[i]) begin n_fail++; $display("[TB] FAIL rand%0d_ch_seq[%0d]: got %0d required %0d", it, i, go_ch[i], exp_order[i]); end
        end
      end
      n_checks++;
      if (new_flags !== exp_flags || timeout_err !== exp_terr || done_cnt != 1) begin
        n_fail++; $display("[TB] FAIL rand%0d_status: flags=%b terr=%0b done=%0d required %b %0b 1", it, new_flags, timeout_err, done_cnt, exp_flags, exp_terr);
      end
      for (int ch = 0; ch < NCH; ch++) begin
        rd_ch = CHW'(ch); #1;
        n_checks++;
        if (rd_data !== exp_res[ch]) begin n_fail++; $display("[TB] FAIL rand%0d_res[%0d]: got %0h required %0h", it, ch, rd_data, exp_res[ch]); end
      end
    end
    resp_hold = 1'b0;
    resp_silent = '0;
    resp_lat = 10;
  endtask

`ifdef WINDOW_CMP_EN
  task automatic test_window();
    int sc;
    win_lo = 8'h20; win_hi = 8'hC0;
    resp_val[0] = 8'h10; resp_val[1] = 8'h80; resp_val[2] = 8'hF0; resp_val[3] = 8'hC0;
    pulse_clear('1);
    @(negedge clk);
    n_checks++;
    if (alarm !== '0) begin n_fail++; $display("[TB] FAIL window_clear: got %b required 0000", alarm); end
    pulse_start(4'b1111, 1'b0, sc);
    wait_idle("window");
    n_checks++;
    if (alarm !== 4'b0101) begin n_fail++; $display("[TB] FAIL window_alarm: got %b required 0101", alarm); end
  endtask
`endif

  initial begin
    test_reset();
    test_single_scan();
    test_ignored_start();
    test_timeout();
    test_continuous();
    test_mid_reset();
    test_random();
`ifdef WINDOW_CMP_EN
    test_window();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
